tank_level_ctrl: RTL
====================

// Module: tank_level_ctrl
// PURPOSE
//  Parametrised water-tank controller, successor to the two-sensor (Bot/Top) level decoder.
//  Takes NUM_SENSORS stacked wet/dry level sensors (bit 0 = bottom), debounces each one and
//  encodes the filtered level. Drives a fill pump with LOW/HIGH hysteresis. Raises a sticky
//  fault when the sensor pattern is physically impossible (upper wet, lower dry).
//  Sits between the raw sensor pins and the pump driver / status display.
// PARAMETERS
//  NUM_SENSORS      4  number of stacked level sensors (>=2)
//  DEBOUNCE_CYCLES  4  consecutive stable samples before a sensor bit is accepted (>=1)
//  FAULT_CYCLES     8  consecutive invalid-pattern cycles before FAULT is entered (>=1)
//  LOW_MARK         1  pump starts when level <= LOW_MARK
//  HIGH_MARK        4  pump stops when level >= HIGH_MARK; rule: LOW_MARK < HIGH_MARK <= NUM_SENSORS
//  PUMP_TIMEOUT   256  max FILL cycles (used only with TANK_PUMP_TIMEOUT_EN)
// PORTS
//  clk         in   1                          system clock, rising edge
//  rst_n       in   1                          asynchronous active-low reset
//  sensors     in   NUM_SENSORS                raw sensor bits, 1 = wet; async, 2-flop synchronised inside
//  auto_en     in   1                          1 = automatic pump control; 0 = pump forced off
//  fault_clr   in   1                          single-cycle pulse, clears FAULT
//  level       out  $clog2(NUM_SENSORS+1)      number of wet filtered sensors (valid pattern only)
//  pump_on     out  1                          pump drive
//  alarm_low   out  1                          level == 0
//  alarm_high  out  1                          level == NUM_SENSORS
//  fault       out  1                          state == FAULT
//  fault_code  out  2                          01 invalid pattern, 10 pump timeout, 00 none
// BEHAVIOUR
//  Reset (async, rst_n=0): sync flops, filtered bits, all counters = 0; state IDLE;
//   level=0, pump_on=0, alarm_low=1, alarm_high=0, fault=0, fault_code=00.
//  Debounce, per bit: raw==filt -> counter cleared. raw!=filt -> counter increments.
//   When counter == DEBOUNCE_CYCLES-1 and raw still differs: filt<=raw, counter cleared.
//   A glitch shorter than DEBOUNCE_CYCLES samples never reaches filt.
//  Valid pattern: filt is a thermometer code (all ones contiguous from bit 0).
//  Level is registered, updated only while the pattern is valid; it holds its last value while invalid.
//  Latency: synchronised change -> level/alarms = DEBOUNCE_CYCLES+1 clocks. pump_on follows level by 1 clock.
//  Invalid counter: increments on each invalid cycle, clears on a valid cycle, saturates at FAULT_CYCLES.
//  FSM: IDLE (pump off), FILL (pump on), FAULT (pump off, fault=1).
//   IDLE -> FILL    when auto_en & valid & level<=LOW_MARK
//   FILL -> IDLE    when level>=HIGH_MARK or auto_en==0
//   any  -> FAULT   when invalid counter reaches FAULT_CYCLES; fault_code=01; highest priority
//   FAULT -> IDLE   on fault_clr & valid pattern; fault_code=00. fault_clr with invalid pattern is ignored.
//   fault_clr outside FAULT: no effect.
//  Level between the marks holds the current state (hysteresis).
//  Simultaneous fault trigger and fault_clr: the fault wins.
//  Reset during FILL: pump_on drops immediately (async).
// CONFIGURATION
//  TANK_PUMP_TIMEOUT_EN defined: a run counter counts FILL cycles and clears on leaving FILL.
//   When it reaches PUMP_TIMEOUT in FILL -> FAULT, fault_code=10. Cleared by the same fault_clr rule.
//  Not defined: no run counter; FILL lasts indefinitely; fault_code never 10.
// TESTING (NUM_SENSORS=4, DEBOUNCE=4, FAULT=8, LOW=1, HIGH=4)
//  1 Reset, sensors=0000, auto_en=1 -> level=0, alarm_low=1; pump_on=1 within DEBOUNCE+3 clocks
//  2 Fill steps 0001,0011,0111,1111 held 10 clks each -> level 1..4; pump_on stays 1 until level=4
//    then 0; alarm_high=1
//  3 Drain 1111->0111->0011 -> pump stays 0 (hysteresis); 0001 -> pump_on=1
//  4 Bit 2 pulsed high 3 clks on 0001 -> filt/level unchanged, no fault
//  5 Sensors=0101 held 20 clks -> fault=1, fault_code=01, pump_on=0, level holds 1;
//    fault_clr while 0101 -> still fault; set 0011 then fault_clr -> IDLE, fault=0
//  6 [TANK_PUMP_TIMEOUT_EN, PUMP_TIMEOUT=16] sensors=0000 held -> FAULT after 16 FILL clocks,
//    fault_code=10; rst_n low mid-FILL -> pump_on=0 with no clock edge

Source files
------------

// File: rtl/tank_level_ctrl_if.sv
// ---------------------------------------------------------------------------
// tank_level_ctrl_if
// Groups the sensor, control and status signals of the water-tank controller.
//   master : drives sensors/auto_en/fault_clr, observes the status outputs
//   slave  : the controller itself
// Signals
//   sensors    [NUM_SENSORS-1:0]  raw wet/dry sensor bits, bit 0 = bottom
//   auto_en                       1 = automatic pump control, 0 = pump forced off
//   fault_clr                     single-cycle fault clear pulse
//   level      [LW-1:0]           filtered level (number of wet sensors)
//   pump_on                       pump drive
//   alarm_low / alarm_high        level empty / level full
//   fault                         controller is in FAULT
//   fault_code [1:0]              01 invalid pattern, 10 pump timeout, 00 none
// ---------------------------------------------------------------------------
interface tank_level_ctrl_if #(
    parameter int NUM_SENSORS = 4
);
    localparam int LW = $clog2(NUM_SENSORS + 1);

    logic [NUM_SENSORS-1:0] sensors;
    logic                   auto_en;
    logic                   fault_clr;
    logic [LW-1:0]          level;
    logic                   pump_on;
    logic                   alarm_low;
    logic                   alarm_high;
    logic                   fault;
    logic [1:0]             fault_code;

    modport master (
        output sensors, auto_en, fault_clr,
        input  level, pump_on, alarm_low, alarm_high, fault, fault_code
    );

    modport slave (
        input  sensors, auto_en, fault_clr,
        output level, pump_on, alarm_low, alarm_high, fault, fault_code
    );
endinterface

// File: rtl/tank_level_ctrl.sv
// ---------------------------------------------------------------------------
// tank_level_ctrl
// Water-tank controller: synchronises and debounces NUM_SENSORS stacked level
// sensors, encodes the filtered thermometer pattern into a level, drives a
// fill pump with LOW_MARK/HIGH_MARK hysteresis and raises a sticky fault when
// the pattern is physically impossible (upper sensor wet, lower one dry).
//
// Ports
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : tank_level_ctrl_if.slave (sensors, auto_en, fault_clr in;
//            level, pump_on, alarm_low, alarm_high, fault, fault_code out)
//
// Optional feature
//   TANK_PUMP_TIMEOUT_EN : when defined, a run counter limits a FILL episode
//   to PUMP_TIMEOUT cycles and enters FAULT with fault_code 10 on expiry.
//   When undefined, FILL lasts indefinitely and fault_code is never 10.
// ---------------------------------------------------------------------------
module tank_level_ctrl #(
    parameter int NUM_SENSORS     = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FAULT_CYCLES    = 8,
    parameter int LOW_MARK        = 1,
    parameter int HIGH_MARK       = 4,
    parameter int PUMP_TIMEOUT    = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    tank_level_ctrl_if.slave bus
);
    localparam int LW  = $clog2(NUM_SENSORS + 1);
    localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int FCW = $clog2(FAULT_CYCLES + 1);

    if (NUM_SENSORS < 2 || DEBOUNCE_CYCLES < 1 || FAULT_CYCLES < 1 ||
        LOW_MARK >= HIGH_MARK || HIGH_MARK > NUM_SENSORS || PUMP_TIMEOUT < 1) begin : g_param_check
        $error("tank_level_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, FILL, FAULT} state_t;

    // A valid pattern is a thermometer code: v+1 is a power of two.
    function automatic logic is_therm(input logic [NUM_SENSORS-1:0] v);
        return (v & (v + 1'b1)) == '0;
    endfunction

    function automatic logic [LW-1:0] count_ones(input logic [NUM_SENSORS-1:0] v);
        logic [LW-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            n = n + LW'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [FCW-1:0] sat_inc(input logic [FCW-1:0] c);
        return (c == FCW'(FAULT_CYCLES)) ? c : c + 1'b1;
    endfunction

    logic [NUM_SENSORS-1:0] sync_p0, sync_p1;
    logic [NUM_SENSORS-1:0] filt_p2;
    logic [DCW-1:0]         db_cnt [NUM_SENSORS];
    logic [LW-1:0]          level_p3;
    logic [FCW-1:0]         inv_cnt;
    logic                   valid;
    logic                   trig_inv;
    logic                   timeout_hit;
    state_t                 state, state_next;
    logic [1:0]             code_q, code_next;

    // Stage 0/1: two-flop synchroniser on the asynchronous sensor pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= bus.sensors;
            sync_p1 <= sync_p0;
        end
    end

    // Stage 2: per-bit debounce; a bit is accepted after DEBOUNCE_CYCLES
    // consecutive samples that disagree with the current filtered value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_p2 <= '0;
            for (int b = 0; b < NUM_SENSORS; b++) begin
                db_cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_SENSORS; b++) begin
                if (sync_p1[b] == filt_p2[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == DCW'(DEBOUNCE_CYCLES - 1)) begin
                    filt_p2[b] <= sync_p1[b];
                    db_cnt[b]  <= '0;
                end else begin
                    db_cnt[b] <= db_cnt[b] + 1'b1;
                end
            end
        end
    end

    assign valid    = is_therm(filt_p2);
    assign trig_inv = !valid && (inv_cnt >= FCW'(FAULT_CYCLES - 1));

    // Stage 3: level register (holds while the pattern is invalid) and the
    // invalid-pattern persistence counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_p3 <= '0;
            inv_cnt  <= '0;
        end else begin
            if (valid) begin
                level_p3 <= count_ones(filt_p2);
            end
            inv_cnt <= valid ? '0 : sat_inc(inv_cnt);
        end
    end

`ifdef TANK_PUMP_TIMEOUT_EN
    localparam int RCW = $clog2(PUMP_TIMEOUT + 1);
    logic [RCW-1:0] run_cnt;

    // Counts cycles spent in FILL; any exit (including the timeout itself)
    // clears it so the next FILL episode starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
        end else if (state == FILL && state_next == FILL) begin
            run_cnt <= run_cnt + 1'b1;
        end else begin
            run_cnt <= '0;
        end
    end

    assign timeout_hit = (state == FILL) && (run_cnt == RCW'(PUMP_TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Stage 4: pump/fault state machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            code_q <= 2'b00;
        end else begin
            state  <= state_next;
            code_q <= code_next;
        end
    end

    always_comb begin
        state_next = state;
        code_next  = code_q;
        if (trig_inv) begin
            // Fault entry outranks every other transition, including fault_clr.
            state_next = FAULT;
            code_next  = 2'b01;
        end else if (timeout_hit) begin
            state_next = FAULT;
            code_next  = 2'b10;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.auto_en && valid && level_p3 <= LW'(LOW_MARK)) begin
                        state_next = FILL;
                    end
                end
                FILL: begin
                    if (level_p3 >= LW'(HIGH_MARK) || !bus.auto_en) begin
                        state_next = IDLE;
                    end
                end
                FAULT: begin
                    if (bus.fault_clr && valid) begin
                        state_next = IDLE;
                        code_next  = 2'b00;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Pump and fault decode straight from the state register so an
    // asynchronous reset drops the pump without waiting for a clock.
    assign bus.level      = level_p3;
    assign bus.pump_on    = (state == FILL);
    assign bus.fault      = (state == FAULT);
    assign bus.fault_code = code_q;
    assign bus.alarm_low  = (level_p3 == '0);
    assign bus.alarm_high = (level_p3 == LW'(NUM_SENSORS));
endmodule
